// File: rtl/div_bcd_pkg.sv
// Shared types and sizing constants for the divider-result BCD converter.
package div_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV_Q = 2'd1,
        CONV_R = 2'd2,
        DONE   = 2'd3
    } dbcd_state_t;

    localparam int DBCD_W      = 16;
    localparam int DBCD_DIGITS = 5;
    localparam int DBCD_BCD_W  = 4 * DBCD_DIGITS;
    localparam int DBCD_CNT_W  = $clog2(DBCD_W);

endpackage

// File: rtl/div_result_bcd_dd_step.sv
// One double-dabble iteration over {bcd, binary}: add 3 to every BCD nibble >= 5,
// then shift the whole working register left by one.
module dd_step #(
    parameter int W      = 16,
    parameter int DIGITS = 5
) (
    input  logic [4*DIGITS+W-1:0] i_work,
    output logic [4*DIGITS+W-1:0] o_work
);

    logic [4*DIGITS+W-1:0] w_adj;

    always_comb begin
        w_adj = i_work;
        for (int d = 0; d < DIGITS; d++) begin
            if (i_work[W+4*d +: 4] >= 4'd5)
                w_adj[W+4*d +: 4] = i_work[W+4*d +: 4] + 4'd3;
        end
        o_work = {w_adj[4*DIGITS+W-2:0], 1'b0};
    end

endmodule

// File: rtl/div_result_bcd.sv
// Captures one quotient/remainder pair and converts both to packed BCD,
// one double-dabble iteration per clock, with valid/ready on both sides.
module div_result_bcd
    import div_bcd_pkg::*;
#(
    parameter int W      = DBCD_W,
    parameter int DIGITS = DBCD_DIGITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        quotient,
    input  logic [W-1:0]        remainder,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] q_bcd,
    output logic [4*DIGITS-1:0] r_bcd,
    output logic                busy
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int CNT_W  = $clog2(W);
    localparam int WORK_W = BCD_W + W;

    dbcd_state_t       r_state;
    dbcd_state_t       w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [W-1:0]      r_q_sh;
    logic [W-1:0]      r_r_sh;
    logic [BCD_W-1:0]  r_acc;
    logic [BCD_W-1:0]  r_qres;
    logic [BCD_W-1:0]  r_q_bcd;
    logic [BCD_W-1:0]  r_r_bcd;
    logic [WORK_W-1:0] w_work_in;
    logic [WORK_W-1:0] w_work_out;
    logic              w_last;

    // The single step instance is shared: the binary field selects the active shadow.
    assign w_work_in = (r_state == CONV_R) ? {r_acc, r_r_sh} : {r_acc, r_q_sh};
    assign w_last    = (r_cnt == CNT_W'(W - 1));

    dd_step #(.W(W), .DIGITS(DIGITS)) u_step (
        .i_work (w_work_in),
        .o_work (w_work_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next = CONV_Q;
            CONV_Q:  if (w_last)    w_next = CONV_R;
            CONV_R:  if (w_last)    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default:                w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_q_sh  <= '0;
            r_r_sh  <= '0;
            r_acc   <= '0;
            r_qres  <= '0;
            r_q_bcd <= '0;
            r_r_bcd <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_q_sh <= quotient;
                        r_r_sh <= remainder;
                        r_acc  <= '0;
                        r_cnt  <= '0;
                    end
                end
                CONV_Q: begin
                    r_q_sh <= w_work_out[W-1:0];
                    r_cnt  <= r_cnt + CNT_W'(1);
                    r_acc  <= w_work_out[WORK_W-1:W];
                    if (w_last) begin
                        r_qres <= w_work_out[WORK_W-1:W];
                        r_acc  <= '0;
                        r_cnt  <= '0;
                    end
                end
                CONV_R: begin
                    r_r_sh <= w_work_out[W-1:0];
                    r_cnt  <= r_cnt + CNT_W'(1);
                    r_acc  <= w_work_out[WORK_W-1:W];
                    if (w_last) begin
                        r_q_bcd <= r_qres;
                        r_r_bcd <= w_work_out[WORK_W-1:W];
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == CONV_Q) || (r_state == CONV_R);
    assign q_bcd     = r_q_bcd;
    assign r_bcd     = r_r_bcd;

endmodule

// File: doc/div_result_bcd.md
# div_result_bcd

Sequential binary-to-BCD converter that sits directly downstream of `system_divider`. It captures one 16-bit quotient/remainder pair from the divider result registers and converts both values to 5-digit packed BCD for display. The algorithm is iterative shift-and-add-3 (double dabble), one iteration per clock. Results are held until the consumer accepts them, using valid/ready handshakes on both sides.

## Interface
- `W`, 16: binary operand width.
- `DIGITS`, 5: BCD digits per result. Must satisfy 10^DIGITS > 2^W − 1.
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: `quotient`/`remainder` are valid for capture.
- `in_ready`  out  1: block can accept an operand pair.
- `quotient`  in  W: divider quotient.
- `remainder`  in  W: divider remainder.
- `out_valid`  out  1: `q_bcd`/`r_bcd` hold a completed conversion.
- `out_ready`  in  1: consumer accepts the result.
- `q_bcd`  out  4·DIGITS: packed BCD of the quotient; digit 0 is in bits [3:0].
- `r_bcd`  out  4·DIGITS: packed BCD of the remainder.
- `busy`  out  1: conversion in progress (state CONV_Q or CONV_R).

## Operation
- FSM states are IDLE, CONV_Q, CONV_R and DONE.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`, capture `quotient` and `remainder` into the binary shadow registers.
  - Clear the BCD accumulator and set iteration count=0.
  - Go to CONV_Q.
- **CONV_Q:**
  - Each clock performs one iteration on the {bcd_acc, q_shadow} working register, which is 4·DIGITS+W bits wide.
  - Iteration step 1: every BCD nibble ≥5 gets +3. This is per-nibble, with no carry between nibbles.
  - Iteration step 2: shift left 1. The MSB of the binary field enters bit 0 of the BCD field.
  - When count==W−1, latch bcd_acc into the internal q result, clear bcd_acc, set count=0, and go to CONV_R.
- **CONV_R:**
  - Same iteration on {bcd_acc, r_shadow}.
  - When count==W−1, load `q_bcd` and `r_bcd` from the results and go to DONE.
- **DONE:**
  - `out_valid`=1.
  - On `out_ready`, go to IDLE.
  - `in_ready`=0 in DONE; there is no same-cycle re-acceptance.
- `in_valid` is ignored in every state except IDLE. Inputs are not sampled after capture.
- `q_bcd`/`r_bcd` change only on entry to DONE. They hold their previous values during conversion.
- Every nibble of a completed result is in 0..9. All W-bit inputs are legal, including 0 and 2^W−1. A divide-by-zero result from the divider is converted as an ordinary value.
- `in_ready`, `out_valid` and `busy` are pure state decodes, registered with no combinational path from the inputs.

## Timing
- **Reset values:**
  - State=IDLE.
  - `in_ready`=1.
  - `out_valid`=0.
  - `busy`=0.
  - `q_bcd`=0, `r_bcd`=0.
  - Shadows, accumulator and count all 0.
- **Latency:**
  - Acceptance happens at edge T.
  - Quotient iterations run at edges T+1..T+16.
  - Remainder iterations run at edges T+17..T+32.
  - `out_valid` goes high after edge T+32, i.e. 2·W cycles after acceptance.
- **Throughput:** one pair per 2·W+2 cycles minimum, when `out_ready` is held high.
- **Backpressure:** `out_valid` and the results are stable while `out_ready`=0, for any duration.
- **Reset mid-operation:** `rst` asserted in any state returns all reset values immediately (asynchronous). The partial conversion is discarded. The first accept after deassertion starts a fresh conversion.
- Acceptance cannot occur while `rst` is high.

## Structure
- Package `div_bcd_pkg` contains:
  - State enum `dbcd_state_t`.
  - Constants `DBCD_W`=16, `DBCD_DIGITS`=5, `DBCD_BCD_W`=4·DIGITS, `DBCD_CNT_W`=$clog2(W).
- Sub-module `dd_step` is a combinational single iteration: per-nibble add-3 followed by a 1-bit shift, over the 4·DIGITS+W working register.
  - It is parameterised by W and DIGITS.
  - One instance is time-shared between the CONV_Q and CONV_R phases.
- The top-level holds the FSM, the counter, the shadows and the output registers.

## Test plan
- **Reset check:** assert `rst` mid-simulation → `out_valid`=0, `busy`=0, `in_ready`=1, `q_bcd`=20'h00000, `r_bcd`=20'h00000 immediately.
- **Basic conversion:** `quotient`=2, `remainder`=0 with a 1-cycle `in_valid` → `out_valid` exactly 32 cycles after acceptance; `q_bcd`=20'h00002, `r_bcd`=20'h00000.
- **Multi-digit:** `quotient`=441, `remainder`=78 → `q_bcd`=20'h00441, `r_bcd`=20'h00078. Then `quotient`=184, `remainder`=17 → `q_bcd`=20'h00184, `r_bcd`=20'h00017.
- **Extremes:** `quotient`=65535, `remainder`=65534 → `q_bcd`=20'h65535, `r_bcd`=20'h65534. `quotient`=0, `remainder`=0 → both 20'h00000.
- **Backpressure:** hold `out_ready`=0 for 10 cycles after `out_valid` → outputs stable, `in_ready`=0, a new `in_valid` pulse is not captured. Raise `out_ready` → IDLE next cycle. A pair presented afterwards (12345, 0) → 20'h12345.
- **Reset mid-conversion:** assert `rst` at iteration 10 of CONV_Q → all outputs return to reset values. Then convert (32767, 1) → `q_bcd`=20'h32767, `r_bcd`=20'h00001 with nominal latency.
